// File: rtl/eth_tx_arbiter_pkg.sv
// Shared constants, FSM state encoding and port helpers for the Ethernet TX arbiter.
package eth_tx_arbiter_pkg;

    localparam int   ETH_TX_MAX_LEN       = 1518;
    // The packet size header goes out most-significant byte first (big-endian).
    localparam logic ETH_TX_HDR_MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_WAIT_RST
    } arb_state_t;

    function automatic logic [1:0] port_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie, the port that was not granted last wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module eth_rr_pick (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_sel,
    output logic       o_any
);

    assign o_any = |i_valid;
    assign o_sel = (&i_valid) ? ~i_last : i_valid[1];

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-level round-robin scheduler feeding the shared Ethernet TX FIFO with header + payload.
// Latency: one IDLE arbitration cycle, two header bytes, then one payload byte per cycle.
// Backpressure: a write stalls while tx_full_i is high; tx_reset_i aborts the current packet.
module eth_tx_arbiter
    import eth_tx_arbiter_pkg::*;
#(
    parameter int MAX_LEN = ETH_TX_MAX_LEN,
    parameter int LEN_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [1:0]         req_valid_i,
    input  logic [2*LEN_W-1:0] req_len_i,
    input  logic [15:0]        req_data_i,
    output logic [1:0]         req_rd_o,
    output logic [1:0]         req_done_o,
    output logic [1:0]         req_err_o,
    output logic [1:0]         grant_o,
    output logic [7:0]         tx_data_o,
    output logic               tx_wr_en_o,
    input  logic               tx_full_i,
    input  logic               tx_reset_i,
    output logic               busy_o,
    output logic [LEN_W-1:0]   pkt_cnt0_o,
    output logic [LEN_W-1:0]   pkt_cnt1_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    // r_sel doubles as last_grant: it only changes on an arbitration.
    logic             r_sel;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [1:0]       r_done;
    logic [LEN_W-1:0] r_pkt_cnt0;
    logic [LEN_W-1:0] r_pkt_cnt1;

    logic             w_pick_sel;
    logic             w_pick_any;
    logic [LEN_W-1:0] w_pick_len;
    logic             w_len_ok;
    logic             w_arb;
    logic             w_active;
    logic             w_wr;
    logic             w_last_byte;

    eth_rr_pick u_pick (
        .i_valid (req_valid_i),
        .i_last  (r_sel),
        .o_sel   (w_pick_sel),
        .o_any   (w_pick_any)
    );

    assign w_pick_len  = w_pick_sel ? req_len_i[2*LEN_W-1:LEN_W] : req_len_i[LEN_W-1:0];
    assign w_len_ok    = (w_pick_len != '0) && (w_pick_len <= MAX_LEN_W);
    assign w_arb       = (r_state == ST_IDLE) && !tx_reset_i && w_pick_any;
    assign w_active    = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) || (r_state == ST_DATA);
    assign w_wr        = w_active && !tx_full_i && !tx_reset_i;
    assign w_last_byte = (r_state == ST_DATA) && w_wr && (r_cnt == LEN_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_data_o   = 8'h00;
        req_rd_o    = 2'b00;
        req_err_o   = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_arb && w_len_ok) begin
                    w_state_nxt = ST_LEN_HI;
                end else if (w_arb) begin
                    req_err_o = port_onehot(w_pick_sel);
                end
            end
            ST_LEN_HI: begin
                tx_data_o = ETH_TX_HDR_MSB_FIRST ? r_len[15:8] : r_len[7:0];
                if (tx_reset_i)  w_state_nxt = ST_WAIT_RST;
                else if (w_wr)   w_state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                tx_data_o = ETH_TX_HDR_MSB_FIRST ? r_len[7:0] : r_len[15:8];
                if (tx_reset_i)  w_state_nxt = ST_WAIT_RST;
                else if (w_wr)   w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                tx_data_o = r_sel ? req_data_i[15:8] : req_data_i[7:0];
                if (w_wr) req_rd_o = port_onehot(r_sel);
                if (tx_reset_i)       w_state_nxt = ST_WAIT_RST;
                else if (w_last_byte) w_state_nxt = ST_IDLE;
            end
            ST_WAIT_RST: begin
                if (!tx_reset_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // The requester learns of an abort in the same cycle the flush is seen.
        if (w_active && tx_reset_i) req_err_o = port_onehot(r_sel);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sel      <= 1'b1;
            r_len      <= '0;
            r_cnt      <= '0;
            r_done     <= 2'b00;
            r_pkt_cnt0 <= '0;
            r_pkt_cnt1 <= '0;
        end else begin
            r_done <= 2'b00;
            if (w_arb) begin
                r_sel <= w_pick_sel;
                r_len <= w_pick_len;
            end
            if ((r_state == ST_LEN_LO) && w_wr) begin
                r_cnt <= r_len;
            end else if ((r_state == ST_DATA) && w_wr) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end
            if (w_last_byte) begin
                r_done <= port_onehot(r_sel);
                if (r_sel) r_pkt_cnt1 <= r_pkt_cnt1 + LEN_W'(1);
                else       r_pkt_cnt0 <= r_pkt_cnt0 + LEN_W'(1);
            end
        end
    end

    assign tx_wr_en_o = w_wr;
    assign grant_o    = w_active ? port_onehot(r_sel) : 2'b00;
    assign busy_o     = (r_state != ST_IDLE);
    assign req_done_o = r_done;
    assign pkt_cnt0_o = r_pkt_cnt0;
    assign pkt_cnt1_o = r_pkt_cnt1;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: queue-driven requesters, a frame-position reference model and directed scenarios.
module tb_eth_tx_arbiter;

    localparam int MAXL = 1518;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [31:0] req_len_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_rd_o, req_done_o, req_err_o, grant_o;
    logic [7:0]  tx_data_o;
    logic        tx_wr_en_o, tx_full_i, tx_reset_i, busy_o;
    logic [15:0] pkt_cnt0_o, pkt_cnt1_o;

    eth_tx_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_len_i   (req_len_i),
        .req_data_i  (req_data_i),
        .req_rd_o    (req_rd_o),
        .req_done_o  (req_done_o),
        .req_err_o   (req_err_o),
        .grant_o     (grant_o),
        .tx_data_o   (tx_data_o),
        .tx_wr_en_o  (tx_wr_en_o),
        .tx_full_i   (tx_full_i),
        .tx_reset_i  (tx_reset_i),
        .busy_o      (busy_o),
        .pkt_cnt0_o  (pkt_cnt0_o),
        .pkt_cnt1_o  (pkt_cnt1_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Requesters: pending packet lengths and the concatenated payload bytes of accepted-size packets.
    int         q_len[2][$];
    logic [7:0] q_dat[2][$];
    int         q_idx[2];

    logic full_cmd = 1'b0;
    logic trst_cmd = 1'b0;

    // Reference model: a packet is a frame {len_hi, len_lo, payload...}; m_pos is the next frame byte.
    logic        m_act, m_wait, m_own, m_last;
    int          m_pos, m_len;
    logic [1:0]  m_done;
    logic [15:0] m_cnt0, m_cnt1;

    logic [7:0] wlog[$];
    int         wcyc[$];
    int         glog[$];
    int         gcyc[$];
    int         done_cnt[2];
    int         err_cnt[2];
    int         rd_full;
    logic [1:0] prev_grant = 2'b00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic len_ok(input int len);
        return (len >= 1) && (len <= MAXL);
    endfunction

    task automatic push_pkt(input int p, input int len, input logic [7:0] b0);
        q_len[p].push_back(len);
        if (len_ok(len))
            for (int i = 0; i < len; i++) q_dat[p].push_back(b0 + 8'(i));
    endtask

    task automatic model_reset();
        m_act = 0; m_wait = 0; m_own = 0; m_last = 1;
        m_pos = 0; m_len = 0; m_done = 2'b00; m_cnt0 = 16'd0; m_cnt1 = 16'd0;
    endtask

    task automatic clear_reqs();
        for (int p = 0; p < 2; p++) begin
            q_len[p].delete(); q_dat[p].delete(); q_idx[p] = 0;
        end
    endtask

    task automatic clear_logs();
        wlog.delete(); wcyc.delete(); glog.delete(); gcyc.delete();
        done_cnt = '{0, 0}; err_cnt = '{0, 0}; rd_full = 0;
    endtask

    task automatic step();
        logic [1:0] v, e_rd, e_err, e_grant, done_n;
        logic       e_wr, e_busy, pick, good;
        logic [7:0] e_data;
        int         plen, rem;
        @(negedge clk_i);
        for (int p = 0; p < 2; p++) v[p] = (q_len[p].size() != 0);
        req_valid_i = v;
        req_len_i   = {16'(v[1] ? q_len[1][0] : 0), 16'(v[0] ? q_len[0][0] : 0)};
        req_data_i  = {(q_dat[1].size() != 0) ? q_dat[1][0] : 8'h00,
                       (q_dat[0].size() != 0) ? q_dat[0][0] : 8'h00};
        tx_full_i   = full_cmd;
        tx_reset_i  = trst_cmd;
        #1;
        cyc++;

        e_grant = m_act ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        e_busy  = m_act | m_wait;
        e_wr    = m_act && !full_cmd && !trst_cmd;
        if (m_pos == 0)      e_data = 8'(m_len >> 8);
        else if (m_pos == 1) e_data = 8'(m_len);
        else                 e_data = (q_dat[m_own].size() != 0) ? q_dat[m_own][0] : 8'h00;
        e_rd  = (e_wr && m_pos >= 2) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        e_err = 2'b00;
        pick = 0; good = 0; plen = 0;
        if (!m_act && !m_wait && !trst_cmd && v != 2'b00) begin
            pick = (v == 2'b11) ? !m_last : v[1];
            plen = q_len[pick][0];
            good = len_ok(plen);
            if (!good) e_err[pick] = 1'b1;
        end
        if (m_act && trst_cmd) e_err = m_own ? 2'b10 : 2'b01;

        chk("grant", grant_o, e_grant);
        chk("busy", busy_o, e_busy);
        chk("wr_en", tx_wr_en_o, e_wr);
        if (e_wr) chk("tx_data", tx_data_o, e_data);
        chk("req_rd", req_rd_o, e_rd);
        chk("req_err", req_err_o, e_err);
        chk("req_done", req_done_o, m_done);
        chk("pkt_cnt0", pkt_cnt0_o, m_cnt0);
        chk("pkt_cnt1", pkt_cnt1_o, m_cnt1);

        if (tx_wr_en_o) begin wlog.push_back(tx_data_o); wcyc.push_back(cyc); end
        if (grant_o != 2'b00 && prev_grant == 2'b00) begin
            glog.push_back(int'(grant_o[1])); gcyc.push_back(cyc);
        end
        prev_grant = grant_o;
        for (int p = 0; p < 2; p++) begin
            done_cnt[p] += int'(req_done_o[p]);
            err_cnt[p]  += int'(req_err_o[p]);
        end
        if (req_rd_o != 2'b00 && tx_full_i) rd_full++;

        if (rst_i) begin
            model_reset();
        end else begin
            done_n = 2'b00;
            if (m_wait) begin
                if (!trst_cmd) m_wait = 0;
            end else if (!m_act) begin
                if (v != 2'b00 && !trst_cmd) m_last = pick;
                if (good) begin m_act = 1; m_own = pick; m_pos = 0; m_len = plen; end
            end else if (trst_cmd) begin
                m_act = 0; m_wait = 1;
            end else if (e_wr) begin
                if (m_pos >= 2 && m_pos - 2 == m_len - 1) begin
                    m_act = 0;
                    done_n[m_own] = 1'b1;
                    if (m_own) m_cnt1 = m_cnt1 + 16'd1; else m_cnt0 = m_cnt0 + 16'd1;
                end else begin
                    m_pos++;
                end
            end
            m_done = done_n;
            for (int p = 0; p < 2; p++) begin
                if (e_rd[p]) begin
                    void'(q_dat[p].pop_front());
                    q_idx[p]++;
                    if (q_idx[p] == q_len[p][0]) begin void'(q_len[p].pop_front()); q_idx[p] = 0; end
                end
                if (e_err[p]) begin
                    rem = len_ok(q_len[p][0]) ? q_len[p][0] - q_idx[p] : 0;
                    repeat (rem) void'(q_dat[p].pop_front());
                    void'(q_len[p].pop_front());
                    q_idx[p] = 0;
                end
            end
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((m_act || m_wait || q_len[0].size() != 0 || q_len[1].size() != 0) && n < budget) begin
            step(); n++;
        end
        chk("drain_budget", n < budget, 1);
        step(); step();
    endtask

    initial begin
        logic [7:0] exp_tie[21];
        int n, fall;
        rst_i = 1'b1; req_valid_i = 2'b00; req_len_i = '0; req_data_i = '0;
        tx_full_i = 1'b0; tx_reset_i = 1'b0;
        model_reset(); clear_reqs(); clear_logs();
        #3;
        chk("rst_grant", grant_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wr_en", tx_wr_en_o, 0);
        chk("rst_done", req_done_o, 0);
        chk("rst_err", req_err_o, 0);
        chk("rst_cnt0", pkt_cnt0_o, 0);
        step(); step();
        #1 rst_i = 1'b0;

        // Tie: three packets per port, strict alternation starting with port 0.
        push_pkt(0, 2, 8'hD0); push_pkt(0, 2, 8'hD2); push_pkt(0, 2, 8'hD4);
        push_pkt(1, 1, 8'hE0); push_pkt(1, 1, 8'hE1); push_pkt(1, 1, 8'hE2);
        drain(200);
        exp_tie = '{8'h00, 8'h02, 8'hD0, 8'hD1, 8'h00, 8'h01, 8'hE0,
                    8'h00, 8'h02, 8'hD2, 8'hD3, 8'h00, 8'h01, 8'hE1,
                    8'h00, 8'h02, 8'hD4, 8'hD5, 8'h00, 8'h01, 8'hE2};
        chk("tie_bytes", wlog.size(), 21);
        chk("tie_grants", glog.size(), 6);
        for (int i = 0; i < 21 && i < wlog.size(); i++) chk("tie_byte", wlog[i], exp_tie[i]);
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("tie_order", glog[i], i % 2);
        chk("tie_cnt0", pkt_cnt0_o, 3);
        chk("tie_cnt1", pkt_cnt1_o, 3);

        // Single packet on port 0.
        clear_logs();
        push_pkt(0, 3, 8'hA1);
        drain(100);
        chk("single_bytes", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            chk("single_byte", wlog[i], (i == 0) ? 8'h00 : (i == 1) ? 8'h03 : 8'hA1 + 8'(i - 2));
        if (wcyc.size() == 5) chk("single_consec", wcyc[4] - wcyc[0], 4);
        chk("single_done", done_cnt[0], 1);
        chk("single_cnt0", pkt_cnt0_o, 4);

        // Back-pressure: full for 3 cycles after the 2nd payload byte.
        clear_logs();
        push_pkt(1, 4, 8'hB1);
        n = 0;
        begin
            int fl = 3;
            do begin
                full_cmd = (m_act && m_pos == 4 && fl > 0);
                if (full_cmd) fl--;
                step(); n++;
            end while (m_act && n < 50);
        end
        full_cmd = 1'b0;
        step(); step();
        chk("bp_cycles", n, 10);
        chk("bp_bytes", wlog.size(), 6);
        for (int i = 2; i < 6 && i < wlog.size(); i++) chk("bp_byte", wlog[i], 8'hB1 + 8'(i - 2));
        chk("bp_rd_full", rd_full, 0);
        chk("bp_done", done_cnt[1], 1);

        // Rejects on port 0 (0 and MAX+1), a maximum-size packet, and port 1 served normally.
        clear_logs();
        push_pkt(0, 0, 8'h00); push_pkt(0, 1519, 8'h00); push_pkt(0, 1518, 8'h11);
        push_pkt(1, 2, 8'hC0);
        drain(3000);
        chk("rej_err0", err_cnt[0], 2);
        chk("rej_bytes", wlog.size(), 4 + 1520);
        if (wlog.size() >= 6) begin
            chk("rej_p1_hi", wlog[1], 8'h02);
            chk("rej_p1_d0", wlog[2], 8'hC0);
            chk("rej_max_hi", wlog[4], 8'h05);
            chk("rej_max_lo", wlog[5], 8'hEE);
        end
        chk("rej_done0", done_cnt[0], 1);
        chk("rej_cnt0", pkt_cnt0_o, 5);
        chk("rej_cnt1", pkt_cnt1_o, 5);

        // Abort: flush for 2 cycles after the 5th payload byte of a 64-byte packet.
        clear_logs();
        push_pkt(0, 64, 8'h40);
        n = 0;
        while (!(m_act && m_pos == 7) && n < 100) begin step(); n++; end
        chk("abort_reach", n < 100, 1);
        push_pkt(1, 1, 8'h77);
        trst_cmd = 1'b1;
        step();
        step();
        chk("abort_wait_busy", busy_o, 1);
        chk("abort_wait_grant", grant_o, 0);
        trst_cmd = 1'b0;
        fall = cyc + 1;
        drain(200);
        chk("abort_err0", err_cnt[0], 1);
        chk("abort_bytes", wlog.size(), 10);
        chk("abort_grants", gcyc.size(), 2);
        if (gcyc.size() == 2) chk("abort_regrant", gcyc[1] - fall, 2);
        chk("abort_cnt0", pkt_cnt0_o, 5);

        // Asynchronous reset in the middle of a payload.
        clear_logs();
        push_pkt(0, 8, 8'h60);
        n = 0;
        while (!(m_act && m_pos == 4) && n < 50) begin step(); n++; end
        step();
        chk("ar_pre_wr", tx_wr_en_o, 1);
        #1 rst_i = 1'b1;
        #1;
        chk("ar_wr_en", tx_wr_en_o, 0);
        chk("ar_grant", grant_o, 0);
        chk("ar_busy", busy_o, 0);
        chk("ar_cnt0", pkt_cnt0_o, 0);
        model_reset(); clear_reqs();
        step();
        #1 rst_i = 1'b0;
        clear_logs();
        push_pkt(0, 1, 8'h81); push_pkt(1, 1, 8'h91);
        drain(50);
        chk("ar_grants", glog.size(), 2);
        if (glog.size() == 2) chk("ar_first_tie", glog[0], 0);

        // Randomized traffic with back-pressure and occasional flushes.
        begin
            int tleft = 0;
            for (int c = 0; c < 4000; c++) begin
                for (int p = 0; p < 2; p++) begin
                    if (q_len[p].size() < 3 && $urandom_range(0, 11) == 0) begin
                        int r, len;
                        r = $urandom_range(0, 199);
                        if (r < 8)       len = 0;
                        else if (r < 14) len = 1519 + $urandom_range(0, 100);
                        else if (r == 14) len = 1518;
                        else             len = $urandom_range(1, 24);
                        push_pkt(p, len, 8'($urandom));
                    end
                end
                full_cmd = ($urandom_range(0, 3) == 0);
                if (tleft == 0 && $urandom_range(0, 199) == 0) tleft = $urandom_range(1, 3);
                trst_cmd = (tleft != 0);
                if (tleft != 0) tleft--;
                step();
            end
        end
        full_cmd = 1'b0; trst_cmd = 1'b0;
        drain(20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Packet-level scheduler that shares the Ethernet TX FIFO between two frame sources: port 0 is the CPU/AXI path and port 1 is the USB-capture streamer.
- Grants one requester at a time, round-robin, per whole packet.
- For each packet, writes the 16-bit packet size header (big-endian, two bytes) and then the payload bytes into the TX FIFO.
- Honours TX FIFO back-pressure (full) and the FIFO's TX reset.

Parameters:
- MAX_LEN, 1518, largest accepted payload length in bytes; longer requests are rejected.
- LEN_W, 16, width of length fields and counters.

Ports:
- clk_i  in  1  system clock (32 MHz); single clock domain, TX FIFO write side on same clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  2  per-requester: packet ready, len stable while valid
- req_len_i  in  2*LEN_W  per-requester payload length, [LEN_W-1:0] = port 0
- req_data_i  in  16  per-requester current payload byte (first-word-fall-through), [7:0] = port 0
- req_rd_o  out  2  per-requester byte-consumed pulse; advance data next cycle
- req_done_o  out  2  one-cycle pulse: packet fully written
- req_err_o  out  2  one-cycle pulse: packet rejected or aborted
- grant_o  out  2  one-hot owner of the FIFO, 0 when idle
- tx_data_o  out  8  byte to TX FIFO
- tx_wr_en_o  out  1  TX FIFO write strobe
- tx_full_i  in  1  TX FIFO full
- tx_reset_i  in  1  TX FIFO synchronous reset/flush indication
- busy_o  out  1  state != IDLE
- pkt_cnt0_o  out  LEN_W  packets completed on port 0, wraps
- pkt_cnt1_o  out  LEN_W  packets completed on port 1, wraps

Behaviour:
- Reset values: all outputs 0; state=IDLE; last_grant=1, so port 0 wins the first tie.
- States: IDLE, LEN_HI, LEN_LO, DATA, WAIT_RST.
- IDLE:
  - If tx_reset_i=1: stay in IDLE.
  - Otherwise, if any req_valid_i: pick a requester. If only one is valid, pick it. If both are valid, pick the one != last_grant.
  - Latch len_q and sel_q; update last_grant.
  - If len is 0 or > MAX_LEN: pulse req_err_o[sel] and stay in IDLE. No FIFO write occurs, and no grant is held beyond that cycle.
  - Otherwise go to LEN_HI. grant_o is asserted from LEN_HI onward.
- Write rule, common to LEN_HI, LEN_LO and DATA: tx_wr_en_o = ~tx_full_i & ~tx_reset_i. It is combinational from state; there is at most one byte per cycle. If a write is not performed, the state holds.
- LEN_HI: tx_data_o=len_q[15:8]. On write -> LEN_LO.
- LEN_LO: tx_data_o=len_q[7:0]. On write -> DATA, with cnt_q=len_q.
- DATA:
  - tx_data_o = req_data_i of sel.
  - On write: req_rd_o[sel]=1 in the same cycle, and cnt_q decrements.
  - On the write with cnt_q==1: pulse req_done_o[sel] next cycle, increment pkt_cnt[sel], go to IDLE.
- tx_reset_i=1 in LEN_HI, LEN_LO or DATA:
  - No write that cycle.
  - Pulse req_err_o[sel] and go to WAIT_RST.
  - The requester must discard the remainder of the packet; the arbiter does not drain it.
- WAIT_RST: stay until tx_reset_i=0, then go to IDLE.
- req_valid_i dropping mid-packet is a protocol violation; the arbiter ignores it and continues.
- Minimum packet time is len+3 cycles: 1 IDLE cycle, 2 header cycles, len data cycles.
- Back-to-back packets: a new grant is made in the IDLE cycle right after done.
- Counters wrap at 2^LEN_W-1 -> 0.
- An asynchronous rst_i mid-packet returns everything to reset values immediately. Any partial frame already in the FIFO is recovered by the FIFO's own reset.

Decomposition:
- Shared package/defines file eth_tx_arb_defs.v:
  - state encodings
  - ETH_TX_MAX_LEN
  - header byte order constant
- One sub-module, eth_rr_pick:
  - 2-way round-robin selector
  - inputs: valid[1:0], last
  - outputs: sel, any
  - purely combinational
- The top module holds the FSM, counters and muxes.

Test Plan:
- Single packet: port0 len=3, data 0xA1,0xA2,0xA3, FIFO never full -> FIFO receives 0x00,0x03,0xA1,0xA2,0xA3 on 5 consecutive cycles; one req_done_o[0]; pkt_cnt0_o=1.
- Tie: both ports valid with len=2 and len=1, three packets queued per port -> grant order 0,1,0,1,0,1; no byte interleaving between packets.
- Back-pressure: port1 len=4; tx_full_i high for 3 cycles during DATA after byte 2 -> no writes and no req_rd_o while full; all 6 bytes eventually written in order; total length is 4+2+3+1 cycles.
- Reject: port0 len=0, then len=1519 -> two req_err_o[0] pulses; no tx_wr_en_o; pkt_cnt0_o unchanged; port1 is then served normally.
- Abort: tx_reset_i pulsed for 2 cycles after the 5th data byte of a 64-byte packet -> req_err_o pulse; arbiter sits in WAIT_RST; re-arbitrates one cycle after tx_reset_i falls.
- Async reset mid-DATA: assert rst_i between clock edges -> tx_wr_en_o, grant_o and busy_o drop immediately; port0 wins the next tie.
